auth_check_seq: RTL and testbench
=================================

// Module: auth_check_seq
// PURPOSE
//  Sequences one challenge-response authentication round of the DH key-exchange datapath.
//  - After key agreement, issues a 64-bit nonce (r_1) to the peer.
//  - Accepts the peer's ciphertext c_2 and recovers r1_new = c_2 ^ k.
//  - Compares r1_new with the issued nonce.
//  - Retries with a fresh nonce on failure and locks out after MAX_RETRY failed retries.
//  - Sits between the DH key register (k) and the link interface.
// PARAMETERS
//  W            64          data/key/nonce width
//  MAX_RETRY    3           failed retries allowed before lock (total attempts = MAX_RETRY+1)
//  TIMEOUT_CYC  1024        response wait limit in cycles (used only with AUTH_TIMEOUT_EN)
//  LFSR_SEED    64'hACE1    nonzero reset seed of the nonce LFSR
// PORTS
//  clk         in   1      clock, rising edge
//  rst         in   1      async active-low reset
//  start       in   1      pulse: begin authentication (sampled in IDLE only)
//  key_i       in   W      agreed DH key k; must be stable while busy
//  chal_valid  out  1      nonce offered on chal_data
//  chal_ready  in   1      peer accepts nonce
//  chal_data   out  W      nonce r_1
//  resp_valid  in   1      peer ciphertext c_2 valid
//  resp_ready  out  1      block accepts c_2
//  resp_data   in   W      c_2
//  busy        out  1      high in any state other than IDLE/LOCK
//  auth_ok     out  1      one-cycle pulse: authentication passed
//  auth_fail   out  1      one-cycle pulse: final failure, entering LOCK
//  locked      out  1      level: lockout active
//  retry_cnt   out  2      failed attempts so far in the current sequence
// BEHAVIOUR
//  Reset: every output is 0; state=IDLE; LFSR=LFSR_SEED; retry_cnt=0; internal r1_new/nonce regs=0.
//  LFSR: 64-bit Galois, taps 64,63,61,60. Free-running, advances every cycle, never all-zero.
//  FSM transitions:
//  - IDLE: start=1 -> CHAL. The nonce is latched from the LFSR on the same edge, retry_cnt is cleared,
//    and chal_valid rises the next cycle.
//  - CHAL: chal_valid=1 and chal_data is held stable until chal_valid&chal_ready; then -> WAIT.
//  - WAIT: resp_ready=1. resp_valid&resp_ready latches c_2 -> XOR.
//  - XOR: r1_new <= c_2 ^ key_i -> CMP.
//  - CMP: match <= (r1_new == nonce) -> DONE.
//  - DONE, match: auth_ok=1 for this cycle -> IDLE.
//  - DONE, mismatch, retry_cnt<MAX_RETRY: retry_cnt++, relatch the nonce from the LFSR -> CHAL.
//  - DONE, mismatch, retry_cnt==MAX_RETRY: auth_fail=1 for this cycle -> LOCK.
//  - LOCK: locked=1. Left only through reset. start is ignored.
//  Latency: response accepted at edge n; auth_ok/auth_fail are high in the cycle after edge n+2.
//  Boundaries:
//  - start while busy or locked: ignored, with no side effects.
//  - resp_valid outside WAIT: ignored (resp_ready=0); the data is not latched.
//  - chal_ready without chal_valid: no effect.
//  - key_i changing mid-sequence: the value sampled in XOR is used. No further protection.
//  - resp_data == nonce ^ key_i counts as a match, including the degenerate key_i==0 case.
//  - Reset asserted in any state returns the block to the reset values asynchronously.
//    No pulse is emitted and any partially accepted response is discarded.
// CONFIGURATION
//  `AUTH_TIMEOUT_EN defined:
//  - A timeout counter clears on entry to WAIT and increments each WAIT cycle.
//  - At count==TIMEOUT_CYC-1 with no handshake, the attempt is treated as a mismatch (goes to DONE with match=0).
//  - A handshake in the expiry cycle wins over the timeout.
//  `AUTH_TIMEOUT_EN undefined: no counter logic exists, and WAIT waits indefinitely.
// STRUCTURE
//  auth_pkg:
//  - state encoding: IDLE, CHAL, WAIT, XOR, CMP, DONE, LOCK (3-bit).
//  - width W and LFSR tap mask constants.
//  Sub-module auth_nonce_lfsr: seeded free-running LFSR, output is the full state.
//  XOR/compare stay inline (two registered stages), without a separate checker instance.
// TESTING
//  1. key=64'h0123456789ABCDEF, start; peer answers c_2 = nonce^key -> auth_ok pulse 3 cycles after acceptance,
//     retry_cnt=0, then busy=0.
//  2. Two wrong answers (c_2 = nonce^key^1), then a correct one -> two fresh, differing nonces are offered,
//     retry_cnt=2, then auth_ok.
//  3. Four wrong answers (MAX_RETRY=3) -> auth_fail pulse, then locked=1. A later start is ignored and busy stays 0.
//  4. Hold chal_ready=0 for 10 cycles, assert resp_valid during CHAL -> chal_data stable, resp_ready=0, nothing latched.
//  5. Assert rst in XOR -> all outputs 0 immediately, no auth_ok. start after release runs a normal round.
//  6. With AUTH_TIMEOUT_EN and TIMEOUT_CYC=8, no response -> retry after 8 WAIT cycles.
//     A response in the expiry cycle is accepted.

Source files
------------

// File: rtl/auth_pkg.sv
// Shared state encoding and constants for the challenge-response authentication sequencer.
package auth_pkg;

  localparam int AUTH_W = 64;

  // Galois taps 64,63,61,60 mapped onto bit positions 63,62,60,59 of a right-shifting register
  localparam logic [AUTH_W-1:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CHAL = 3'd1,
    S_WAIT = 3'd2,
    S_XOR  = 3'd3,
    S_CMP  = 3'd4,
    S_DONE = 3'd5,
    S_LOCK = 3'd6
  } auth_state_e;

endpackage

// File: rtl/auth_nonce_lfsr.sv
// Free-running Galois LFSR supplying nonces; advances every cycle, full state is the output.
module auth_nonce_lfsr
  import auth_pkg::*;
#(
  parameter int            W    = AUTH_W,
  parameter logic [W-1:0]  SEED = W'(64'hACE1)
) (
  input  logic         clk,
  input  logic         rst,
  output logic [W-1:0] state_o
);

  logic [W-1:0] lfsr_q;
  logic [W-1:0] lfsr_d;

  // A nonzero seed can never reach all-zero under a Galois update
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[W-1:1]};
    if (lfsr_q[0]) lfsr_d = lfsr_d ^ W'(LFSR_TAPS);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_q <= SEED;
    else      lfsr_q <= lfsr_d;
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/auth_check_seq.sv
// One challenge-response round: issue nonce, recover c_2 ^ k, compare, retry, lock out.
// Latency: auth_ok/auth_fail in the cycle after edge n+2 (n = response accept edge).
// Backpressure: chal_data held until chal_ready; resp_ready only in WAIT; optional WAIT timeout.
module auth_check_seq
  import auth_pkg::*;
#(
  parameter int           W           = AUTH_W,
  parameter int           MAX_RETRY   = 3,
  parameter int           TIMEOUT_CYC = 1024,
  parameter logic [W-1:0] LFSR_SEED   = W'(64'hACE1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] key_i,
  output logic         chal_valid,
  input  logic         chal_ready,
  output logic [W-1:0] chal_data,
  input  logic         resp_valid,
  output logic         resp_ready,
  input  logic [W-1:0] resp_data,
  output logic         busy,
  output logic         auth_ok,
  output logic         auth_fail,
  output logic         locked,
  output logic [1:0]   retry_cnt
);

  localparam logic [1:0] MAX_R = 2'(MAX_RETRY);

  auth_state_e  state_q, state_d;
  logic [W-1:0] nonce_q, nonce_d;
  logic [W-1:0] c2_q, c2_d;
  logic [W-1:0] r1_new_q, r1_new_d;
  logic         match_q, match_d;
  logic [1:0]   retry_q, retry_d;
  logic [W-1:0] lfsr;

`ifdef AUTH_TIMEOUT_EN
  localparam int            TW      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
`endif

  auth_nonce_lfsr #(.W(W), .SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .state_o (lfsr)
  );

  always_comb begin
    state_d    = state_q;
    nonce_d    = nonce_q;
    c2_d       = c2_q;
    r1_new_d   = r1_new_q;
    match_d    = match_q;
    retry_d    = retry_q;
`ifdef AUTH_TIMEOUT_EN
    to_cnt_d   = to_cnt_q;
`endif
    chal_valid = 1'b0;
    resp_ready = 1'b0;
    auth_ok    = 1'b0;
    auth_fail  = 1'b0;
    locked     = 1'b0;
    busy       = 1'b1;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = S_CHAL;
          nonce_d = lfsr;
          retry_d = '0;
        end
      end
      S_CHAL: begin
        chal_valid = 1'b1;
        if (chal_ready) begin
          state_d = S_WAIT;
`ifdef AUTH_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end
      end
      S_WAIT: begin
        resp_ready = 1'b1;
        if (resp_valid) begin
          c2_d    = resp_data;
          state_d = S_XOR;
        end
`ifdef AUTH_TIMEOUT_EN
        else if (to_cnt_q == TO_LAST) begin
          match_d = 1'b0;
          state_d = S_DONE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end
      S_XOR: begin
        r1_new_d = c2_q ^ key_i;
        state_d  = S_CMP;
      end
      S_CMP: begin
        match_d = (r1_new_q == nonce_q);
        state_d = S_DONE;
      end
      S_DONE: begin
        if (match_q) begin
          auth_ok = 1'b1;
          state_d = S_IDLE;
        end else if (retry_q == MAX_R) begin
          auth_fail = 1'b1;
          state_d   = S_LOCK;
        end else begin
          retry_d = retry_q + 1'b1;
          nonce_d = lfsr;
          state_d = S_CHAL;
        end
      end
      S_LOCK: begin
        busy   = 1'b0;
        locked = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      nonce_q  <= '0;
      c2_q     <= '0;
      r1_new_q <= '0;
      match_q  <= 1'b0;
      retry_q  <= '0;
`ifdef AUTH_TIMEOUT_EN
      to_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      nonce_q  <= nonce_d;
      c2_q     <= c2_d;
      r1_new_q <= r1_new_d;
      match_q  <= match_d;
      retry_q  <= retry_d;
`ifdef AUTH_TIMEOUT_EN
      to_cnt_q <= to_cnt_d;
`endif
    end
  end

  assign chal_data = nonce_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_auth_check_seq.sv
// Directed bench for auth_check_seq; timeout scenario runs only with AUTH_TIMEOUT_EN defined.
module tb_auth_check_seq;

  localparam logic [63:0] SEED = 64'hACE1;
  localparam logic [63:0] TAPS = 64'hD800_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [63:0] key = '0;
  logic        chal_valid;
  logic        chal_ready = 1'b0;
  logic [63:0] chal_data;
  logic        resp_valid = 1'b0;
  logic        resp_ready;
  logic [63:0] resp_data = '0;
  logic        busy, auth_ok, auth_fail, locked;
  logic [1:0]  retry_cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] m_lfsr;

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) m_lfsr <= SEED;
    else      m_lfsr <= {1'b0, m_lfsr[63:1]} ^ (m_lfsr[0] ? TAPS : 64'd0);
  end

  auth_check_seq #(.TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst), .start(start), .key_i(key),
    .chal_valid(chal_valid), .chal_ready(chal_ready), .chal_data(chal_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .busy(busy), .auth_ok(auth_ok), .auth_fail(auth_fail), .locked(locked),
    .retry_cnt(retry_cnt)
  );

  task automatic do_start(output logic [63:0] exp_nonce);
    exp_nonce = m_lfsr;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_attempt(input logic [63:0] nonce, input logic wrong,
                             output logic early, output logic ok, output logic fail,
                             output logic [1:0] rc, output logic [63:0] nxt);
    chal_ready = 1'b1;
    @(negedge clk);
    chal_ready = 1'b0;
    resp_valid = 1'b1;
    resp_data  = nonce ^ key ^ {63'd0, wrong};
    @(negedge clk);
    resp_valid = 1'b0;
    early = auth_ok | auth_fail;
    @(negedge clk);
    early = early | auth_ok | auth_fail;
    @(negedge clk);
    ok = auth_ok; fail = auth_fail; rc = retry_cnt; nxt = m_lfsr;
    @(negedge clk);
  endtask

  task automatic test_reset;
    #12;
    n_cmp++; if ({chal_valid, resp_ready, busy, auth_ok, auth_fail, locked} !== 6'b0) begin n_err++; $display("FAIL reset_ctrl got %b want 000000", {chal_valid, resp_ready, busy, auth_ok, auth_fail, locked}); end
    n_cmp++; if (chal_data !== 64'd0) begin n_err++; $display("FAIL reset_chal_data got %h want 0", chal_data); end
    n_cmp++; if (retry_cnt !== 2'd0) begin n_err++; $display("FAIL reset_retry got %0d want 0", retry_cnt); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_pass;
    logic [63:0] n, nxt; logic early, ok, fail; logic [1:0] rc;
    key = 64'h0123456789ABCDEF;
    do_start(n);
    n_cmp++; if (chal_valid !== 1'b1) begin n_err++; $display("FAIL pass_chal_valid got %b want 1", chal_valid); end
    n_cmp++; if (chal_data !== n) begin n_err++; $display("FAIL pass_nonce got %h want %h", chal_data, n); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL pass_busy got %b want 1", busy); end
    run_attempt(n, 1'b0, early, ok, fail, rc, nxt);
    n_cmp++; if (early !== 1'b0) begin n_err++; $display("FAIL pass_early_pulse got %b want 0", early); end
    n_cmp++; if ({ok, fail} !== 2'b10) begin n_err++; $display("FAIL pass_ok_fail got %b want 10", {ok, fail}); end
    n_cmp++; if (rc !== 2'd0) begin n_err++; $display("FAIL pass_retry got %0d want 0", rc); end
    n_cmp++; if ({busy, auth_ok} !== 2'b00) begin n_err++; $display("FAIL pass_after got %b want 00", {busy, auth_ok}); end
  endtask

  task automatic test_retry;
    logic [63:0] n0, n1, n2, nxt; logic early, ok, fail; logic [1:0] rc;
    do_start(n0);
    run_attempt(n0, 1'b1, early, ok, fail, rc, n1);
    n_cmp++; if ({ok, fail} !== 2'b00) begin n_err++; $display("FAIL retry1_pulse got %b want 00", {ok, fail}); end
    n_cmp++; if (chal_data !== n1) begin n_err++; $display("FAIL retry1_nonce got %h want %h", chal_data, n1); end
    n_cmp++; if (chal_data === n0) begin n_err++; $display("FAIL retry1_fresh got %h want not %h", chal_data, n0); end
    n_cmp++; if (retry_cnt !== 2'd1) begin n_err++; $display("FAIL retry1_cnt got %0d want 1", retry_cnt); end
    run_attempt(n1, 1'b1, early, ok, fail, rc, n2);
    n_cmp++; if (chal_data !== n2) begin n_err++; $display("FAIL retry2_nonce got %h want %h", chal_data, n2); end
    n_cmp++; if (retry_cnt !== 2'd2) begin n_err++; $display("FAIL retry2_cnt got %0d want 2", retry_cnt); end
    run_attempt(n2, 1'b0, early, ok, fail, rc, nxt);
    n_cmp++; if ({ok, fail, rc} !== 4'b1010) begin n_err++; $display("FAIL retry3_ok got ok=%b fail=%b rc=%0d want 1 0 2", ok, fail, rc); end
  endtask

  task automatic test_lockout;
    logic [63:0] n; logic early, ok, fail; logic [1:0] rc;
    do_start(n);
    for (int i = 0; i < 3; i++) begin
      run_attempt(n, 1'b1, early, ok, fail, rc, n);
      n_cmp++; if (retry_cnt !== 2'(i + 1)) begin n_err++; $display("FAIL lock_cnt%0d got %0d want %0d", i, retry_cnt, i + 1); end
    end
    run_attempt(n, 1'b1, early, ok, fail, rc, n);
    n_cmp++; if ({ok, fail, rc} !== 4'b0111) begin n_err++; $display("FAIL lock_fail got ok=%b fail=%b rc=%0d want 0 1 3", ok, fail, rc); end
    n_cmp++; if ({locked, busy, auth_fail} !== 3'b100) begin n_err++; $display("FAIL lock_level got %b want 100", {locked, busy, auth_fail}); end
    start = 1'b1; @(negedge clk); start = 1'b0; @(negedge clk);
    n_cmp++; if ({locked, busy, chal_valid} !== 3'b100) begin n_err++; $display("FAIL lock_start_ignored got %b want 100", {locked, busy, chal_valid}); end
  endtask

  task automatic test_backpressure;
    logic [63:0] n, dummy, nxt; logic early, ok, fail; logic [1:0] rc;
    rst = 1'b0; @(negedge clk); rst = 1'b1; @(negedge clk);
    chal_ready = 1'b1; @(negedge clk); @(negedge clk); chal_ready = 1'b0;
    n_cmp++; if ({busy, chal_valid} !== 2'b00) begin n_err++; $display("FAIL idle_chal_ready got %b want 00", {busy, chal_valid}); end
    do_start(n);
    resp_valid = 1'b1; resp_data = 64'hDEAD_BEEF_0000_0001;
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if ({chal_valid, resp_ready, chal_data} !== {2'b10, n}) begin n_err++; $display("FAIL bp_cycle%0d got v=%b r=%b d=%h want 1 0 %h", i, chal_valid, resp_ready, chal_data, n); end
      if (i == 4) do_start(dummy); else @(negedge clk);
    end
    resp_valid = 1'b0;
    run_attempt(n, 1'b0, early, ok, fail, rc, nxt);
    n_cmp++; if ({ok, rc} !== 3'b100) begin n_err++; $display("FAIL bp_final got ok=%b rc=%0d want 1 0", ok, rc); end
  endtask

  task automatic test_reset_mid;
    logic [63:0] n, nxt; logic early, ok, fail, seen; logic [1:0] rc;
    do_start(n);
    chal_ready = 1'b1; @(negedge clk); chal_ready = 1'b0;
    resp_valid = 1'b1; resp_data = n ^ key; @(negedge clk); resp_valid = 1'b0;
    rst = 1'b0; #1;
    n_cmp++; if ({chal_valid, resp_ready, busy, auth_ok, auth_fail, locked, retry_cnt} !== 8'b0) begin n_err++; $display("FAIL midrst_ctrl got %b want 0", {chal_valid, resp_ready, busy, auth_ok, auth_fail, locked, retry_cnt}); end
    n_cmp++; if (chal_data !== 64'd0) begin n_err++; $display("FAIL midrst_data got %h want 0", chal_data); end
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin @(negedge clk); seen = seen | auth_ok; end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin @(negedge clk); seen = seen | auth_ok; end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL midrst_no_ok got %b want 0", seen); end
    key = 64'd0;
    do_start(n);
    n_cmp++; if (chal_data !== n) begin n_err++; $display("FAIL midrst_nonce got %h want %h", chal_data, n); end
    run_attempt(n, 1'b0, early, ok, fail, rc, nxt);
    n_cmp++; if ({ok, fail} !== 2'b10) begin n_err++; $display("FAIL zero_key_ok got %b want 10", {ok, fail}); end
  endtask

`ifdef AUTH_TIMEOUT_EN
  task automatic test_timeout;
    logic [63:0] n, n1;
    key = 64'h1111_2222_3333_4444;
    do_start(n);
    chal_ready = 1'b1; @(negedge clk); chal_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (resp_ready !== 1'b1) begin n_err++; $display("FAIL to_wait%0d got %b want 1", i, resp_ready); end
      @(negedge clk);
    end
    n1 = m_lfsr;
    n_cmp++; if ({resp_ready, auth_ok, auth_fail} !== 3'b000) begin n_err++; $display("FAIL to_done got %b want 000", {resp_ready, auth_ok, auth_fail}); end
    @(negedge clk);
    n_cmp++; if ({chal_valid, retry_cnt, chal_data} !== {1'b1, 2'd1, n1}) begin n_err++; $display("FAIL to_retry got v=%b rc=%0d d=%h want 1 1 %h", chal_valid, retry_cnt, chal_data, n1); end
    chal_ready = 1'b1; @(negedge clk); chal_ready = 1'b0;
    for (int i = 0; i < 7; i++) @(negedge clk);
    resp_valid = 1'b1; resp_data = n1 ^ key;
    n_cmp++; if (resp_ready !== 1'b1) begin n_err++; $display("FAIL to_expiry_rdy got %b want 1", resp_ready); end
    @(negedge clk); resp_valid = 1'b0; @(negedge clk); @(negedge clk);
    n_cmp++; if ({auth_ok, retry_cnt} !== 3'b101) begin n_err++; $display("FAIL to_expiry_ok got ok=%b rc=%0d want 1 1", auth_ok, retry_cnt); end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_single_pass();
    test_retry();
    test_lockout();
    test_backpressure();
    test_reset_mid();
`ifdef AUTH_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
